// File: rtl/spi_txn_scheduler_if.sv
// Requester and SPI-master side signals of the transaction scheduler.
interface spi_txn_scheduler_if;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [5:0]  req_rw;
  logic [5:0]  req_mode;
  logic [23:0] req_data;
  logic [2:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  m_cs;
  logic [1:0]  m_rw;
  logic [1:0]  m_mode;
  logic [7:0]  m_data_in;
  logic [7:0]  m_data_out;
  logic        busy;

  // Requesters plus the shift engine's data_out: drives what the scheduler consumes.
  modport master (
    output req_valid, req_rw, req_mode, req_data, m_data_out,
    input  req_ready, rsp_valid, rsp_data, m_cs, m_rw, m_mode, m_data_in, busy
  );

  // The scheduler itself.
  modport slave (
    input  req_valid, req_rw, req_mode, req_data, m_data_out,
    output req_ready, rsp_valid, rsp_data, m_cs, m_rw, m_mode, m_data_in, busy
  );
endinterface

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler for three single-byte SPI requesters (CS=1..3).
// Owns the master's CS/RW/MODE/data_in for a fixed bit window, returns the
// captured byte to the owner and keeps CS idle for a guard gap afterwards.
module spi_txn_scheduler #(
  parameter int XFER_CYCLES  = 8,
  parameter int GUARD_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  spi_txn_scheduler_if.slave bus
);
  localparam int CMAX = (XFER_CYCLES > GUARD_CYCLES) ? XFER_CYCLES : GUARD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] XLAST = CW'(XFER_CYCLES - 1);
  localparam logic [CW-1:0] GLAST = CW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SETUP2, XFER, CAPTURE, GUARD} state_t;

  state_t        state;
  logic [1:0]    rr_ptr, g, rw;
  logic [7:0]    data;
  logic          nul;
  logic [CW-1:0] cnt;
  logic [1:0]    cs_q, rw_q, mode_q;
  logic [7:0]    din_q, rdata_q;
  logic [2:0]    rvld_q;

  logic          hit;
  logic [1:0]    gidx;
  logic [2:0]    grant;
  logic [1:0]    sel_rw, sel_mode;
  logic [7:0]    sel_data;

  // Arbitration: scan rr_ptr+1, rr_ptr+2, rr_ptr; iterate backwards so the earliest wins.
  always_comb begin
    int i;
    hit  = 1'b0;
    gidx = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      i = (int'(rr_ptr) + 1 + k) % 3;
      if (bus.req_valid[i]) begin
        hit  = 1'b1;
        gidx = 2'(i);
      end
    end
    grant    = (state == IDLE && hit) ? (3'b001 << gidx) : 3'b000;
    sel_rw   = bus.req_rw[{gidx, 1'b0} +: 2];
    sel_mode = bus.req_mode[{gidx, 1'b0} +: 2];
    sel_data = bus.req_data[{gidx, 3'b000} +: 8];
  end

  assign bus.req_ready = grant;
  assign bus.busy      = (state != IDLE);
  assign bus.m_cs      = cs_q;
  assign bus.m_rw      = rw_q;
  assign bus.m_mode    = mode_q;
  assign bus.m_data_in = din_q;
  assign bus.rsp_valid = rvld_q;
  assign bus.rsp_data  = rdata_q;

  // Transaction FSM; every output is registered on entry to the state that shows it.
  // mode_q doubles as last_mode: it only changes on SETUP2 entry or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= 2'd2;
      g       <= 2'd0;
      rw      <= 2'd0;
      data    <= 8'd0;
      nul     <= 1'b0;
      cnt     <= '0;
      cs_q    <= 2'd0;
      rw_q    <= 2'd0;
      mode_q  <= 2'd0;
      din_q   <= 8'd0;
      rdata_q <= 8'd0;
      rvld_q  <= 3'd0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          g      <= gidx;
          rr_ptr <= gidx;
          rw     <= sel_rw;
          data   <= sel_data;
          if (sel_rw == 2'b00) begin
            nul     <= 1'b1;
            rdata_q <= 8'd0;
            state   <= CAPTURE;
          end else begin
            nul <= 1'b0;
            if (sel_mode != mode_q) begin
              mode_q <= sel_mode;
              state  <= SETUP2;
            end else begin
              cs_q  <= gidx + 2'd1;
              rw_q  <= sel_rw;
              din_q <= sel_data;
              state <= SETUP;
            end
          end
        end
        SETUP2: begin
          cs_q  <= g + 2'd1;
          rw_q  <= rw;
          din_q <= data;
          state <= SETUP;
        end
        SETUP: begin
          cnt   <= '0;
          state <= XFER;
        end
        XFER: begin
          if (cnt == XLAST) begin
            rdata_q <= rw[1] ? bus.m_data_out : 8'd0;
            rvld_q  <= 3'b001 << g;
            cs_q    <= 2'd0;
            rw_q    <= 2'd0;
            state   <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Null transactions arrive with no pulse raised yet and spend one extra cycle here.
        CAPTURE: begin
          if (rvld_q == 3'd0) begin
            rvld_q <= 3'b001 << g;
          end else begin
            rvld_q <= 3'd0;
            cnt    <= '0;
            state  <= nul ? IDLE : GUARD;
          end
        end
        GUARD: begin
          if (cnt == GLAST) state <= IDLE;
          else              cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_txn_scheduler.md
Name: spi_txn_scheduler

Overview:
Round-robin transaction scheduler in front of the SPI master shift engine. Three requesters, one per slave select (CS=1,2,3), each submit single-byte transactions carrying their own RW code and SPI MODE. The scheduler grants one requester at a time, then drives the master's CS/RW/MODE/data_in for a fixed bit window. It captures the master's data_out, returns it to the owner, and enforces a CS-idle guard gap between transactions.

Parameters:
XFER_CYCLES, 8, clk cycles CS is held active for the byte (one bit per sclk).
GUARD_CYCLES, 2, clk cycles CS=00 between consecutive transactions (minimum 1).

Ports:
clk  input  1  system clock, also the master's clk
reset  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  3  per-requester transaction request; bit i targets CS=i+1
req_ready  output  3  one-hot grant; transaction accepted on rising edge where req_valid[i]&req_ready[i]
req_rw  input  6  {rw2,rw1,rw0}, 2 bits per requester, master RW encoding
req_mode  input  6  {mode2,mode1,mode0}, SPI MODE 0..3 per requester
req_data  input  24  {d2,d1,d0}, byte to send per requester
rsp_valid  output  3  one-cycle completion pulse to owning requester
rsp_data  output  8  received byte, valid while any rsp_valid bit is high
m_cs  output  2  to master CS; 00 = idle
m_rw  output  2  to master RW
m_mode  output  2  to master MODE
m_data_in  output  8  to master data_in
m_data_out  input  8  from master data_out
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=2 (requester 0 wins first), last_mode=0. Outputs: m_cs=00, m_rw=00, m_mode=00, m_data_in=00, rsp_valid=000, rsp_data=00, busy=0, counters=0.
- States: IDLE, SETUP, SETUP2, XFER, CAPTURE, GUARD.
- IDLE: req_ready is combinational and one-hot. It grants the first valid requester scanning rr_ptr+1, rr_ptr+2, rr_ptr (mod 3); req_ready=000 if none valid or not in IDLE.
- On accept: latch g, rw, mode, data; set rr_ptr=g.
  - If rw==00: go straight to CAPTURE with rsp_data=00, m_cs stays 00 (no bus activity).
  - Otherwise go to SETUP2 if mode!=last_mode, else SETUP.
- SETUP2 (1 cycle): m_mode=new mode, m_cs=00. This lets sclk polarity settle. last_mode<=mode. Then SETUP.
- SETUP (1 cycle): m_cs=g+1, m_rw=rw, m_mode=mode, m_data_in=data. Then XFER with cnt=0.
- XFER: outputs held from SETUP. cnt increments each cycle. After XFER_CYCLES cycles, exit on the edge where cnt==XFER_CYCLES-1.
  - On that edge: rsp_data<=(rw[1] ? m_data_out : 00), rsp_valid[g]<=1, m_cs<=00, m_rw<=00.
- CAPTURE (1 cycle): rsp_valid[g]=1 and rsp_data held. Next: GUARD with cnt=0 (skip GUARD when arriving from the rw==00 path; go to IDLE).
- GUARD: m_cs=00 for GUARD_CYCLES cycles, then IDLE.
- m_mode holds last_mode outside active states and never returns to 0 except on reset. m_data_in holds its last value.
- Accept-to-accept period, no mode change: IDLE1+SETUP1+XFER8+CAPTURE1+GUARD2 = 13 cycles; 14 with a mode change; 3 for rw==00.
- rsp_data holds its value after CAPTURE until the next CAPTURE.
- Request inputs are sampled only at the accept edge. Changes after accept do not affect the current transaction.
- Deasserting req_valid before grant withdraws the request.
- Reset asserted mid-transaction: immediate return to reset values, m_cs=00 asynchronously, no rsp_valid pulse; the transaction is lost.
- The same requester holding req_valid continuously is re-granted only when no other requester is valid.

Test Plan:
- Single write: req0 rw=01 mode=0 data=A5, from reset -> accept cycle 0; m_cs=01, m_data_in=A5 for cycles 1..9; rsp_valid=001 in cycle 10 with rsp_data=00; m_cs=00 cycles 10..12; busy low in cycle 13.
- Read capture: req1 rw=10, m_data_out driven 3C during XFER -> m_cs=10, rsp_valid=010 with rsp_data=3C, m_rw=00 after XFER.
- Round-robin: all three valid continuously, same mode -> grant order 0,1,2,0; accept edges 13 cycles apart; never two bits in req_ready.
- Mode change: req0 mode=0 then req1 mode=3 -> second transaction shows SETUP2 with m_mode=3, m_cs=00 for 1 cycle; accept spacing 14 cycles.
- Null transaction: req2 rw=00 -> m_cs never leaves 00; rsp_valid=100 with rsp_data=00 two cycles after accept; next accept possible 3 cycles after.
- Reset mid-XFER: assert reset=0 at cycle 5 of a transaction -> m_cs=00, busy=0, rsp_valid=000 immediately; after release req0 wins first.
